// File: rtl/tdm_demux_if.sv
// Bus bundle for the TDM demultiplexer: interleaved input beat plus the
// demultiplexed per-channel outputs and framing status.
interface tdm_demux_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = $clog2(N_CH)
);
  logic                     in_valid;
  logic                     in_sof;
  logic [DATA_W-1:0]        in_data;
  logic [N_CH*DATA_W-1:0]   ch_data;
  logic [N_CH-1:0]          ch_valid;
  logic [SEL_W-1:0]         sel;
  logic                     frame_done;
  logic                     sync_err;
  logic                     locked;

  // Source of the interleaved stream; consumes the demultiplexed outputs.
  modport master (
    output in_valid, in_sof, in_data,
    input  ch_data, ch_valid, sel, frame_done, sync_err, locked
  );

  // The demultiplexer itself.
  modport slave (
    input  in_valid, in_sof, in_data,
    output ch_data, ch_valid, sel, frame_done, sync_err, locked
  );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: routes each interleaved sample into its
// channel holding register, tracks frame alignment via in_sof and flags
// framing violations, resynchronising on the next SOF.
module tdm_demux #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic           clk,
  input  logic           rst,
  tdm_demux_if.slave     bus
);

  typedef enum logic {
    S_HUNT,
    S_RUN
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SEL_W-1:0]         r_sel;
  logic [SEL_W-1:0]         w_sel_nxt;
  logic [N_CH*DATA_W-1:0]   r_ch_data;
  logic [N_CH*DATA_W-1:0]   w_ch_data_nxt;
  logic [N_CH-1:0]          r_ch_valid;
  logic [N_CH-1:0]          w_ch_valid_nxt;
  logic                     r_frame_done;
  logic                     w_frame_done_nxt;
  logic                     r_sync_err;
  logic                     w_sync_err_nxt;
  logic                     w_wr_en;
  logic [SEL_W-1:0]         w_wr_idx;

  // State and output registers; everything clears immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_HUNT;
      r_sel        <= '0;
      r_ch_data    <= '0;
      r_ch_valid   <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_ch_data    <= w_ch_data_nxt;
      r_ch_valid   <= w_ch_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_sync_err   <= w_sync_err_nxt;
    end
  end

  // Framing FSM: decide on each beat whether the sample is kept, where it
  // goes, and whether a framing violation occurred.
  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_frame_done_nxt = 1'b0;
    w_sync_err_nxt   = 1'b0;
    w_wr_en          = 1'b0;
    w_wr_idx         = '0;
    if (bus.in_valid) begin
      if (bus.in_sof) begin
        // SOF always restarts the frame; mid-frame SOF aborts the old one.
        w_wr_en     = 1'b1;
        w_wr_idx    = '0;
        w_sel_nxt   = SEL_W'(1);
        w_state_nxt = S_RUN;
        if (r_state == S_RUN && r_sel != '0)
          w_sync_err_nxt = 1'b1;
      end else if (r_state == S_HUNT) begin
        w_sync_err_nxt = 1'b1;
      end else if (r_sel == '0) begin
        // Frame boundary reached without SOF: alignment lost.
        w_sync_err_nxt = 1'b1;
        w_state_nxt    = S_HUNT;
      end else begin
        w_wr_en  = 1'b1;
        w_wr_idx = r_sel;
        if (r_sel == SEL_W'(N_CH - 1)) begin
          w_frame_done_nxt = 1'b1;
          w_sel_nxt        = '0;
        end else begin
          w_sel_nxt = r_sel + SEL_W'(1);
        end
      end
    end
  end

  // Channel write steering: only the selected slice loads, others hold.
  always_comb begin
    w_ch_data_nxt  = r_ch_data;
    w_ch_valid_nxt = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (w_wr_en && w_wr_idx == SEL_W'(k)) begin
        w_ch_data_nxt[k*DATA_W +: DATA_W] = bus.in_data;
        w_ch_valid_nxt[k]                 = 1'b1;
      end
    end
  end

  assign bus.ch_data    = r_ch_data;
  assign bus.ch_valid   = r_ch_valid;
  assign bus.sel        = r_sel;
  assign bus.frame_done = r_frame_done;
  assign bus.sync_err   = r_sync_err;
  assign bus.locked     = (r_state == S_RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed framing scenarios followed by a random
// stream, all checked against a frame-position reference model.
module tb_tdm_demux;
  localparam int N_CH   = 4;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tdm_demux_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();
  tdm_demux #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int fd_cyc[$];

  // Reference model: m_pos = -1 when hunting, otherwise next channel slot
  // expected (0 means the next beat must be SOF).
  int                 m_pos;
  logic [DATA_W-1:0]  m_mem [N_CH];
  logic [N_CH-1:0]    m_cv;
  logic               m_fd;
  logic               m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pos = -1;
    for (int k = 0; k < N_CH; k++) m_mem[k] = '0;
    m_cv = '0; m_fd = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [DATA_W-1:0] d);
    m_cv = '0; m_fd = 1'b0; m_err = 1'b0;
    if (v) begin
      if (s) begin
        if (m_pos > 0) m_err = 1'b1;
        m_mem[0] = d; m_cv = 1; m_pos = 1;
      end else if (m_pos < 0) begin
        m_err = 1'b1;
      end else if (m_pos == 0) begin
        m_err = 1'b1; m_pos = -1;
      end else begin
        m_mem[m_pos] = d;
        m_cv = N_CH'(1) << m_pos;
        if (m_pos == N_CH - 1) begin m_fd = 1'b1; m_pos = 0; end
        else m_pos = m_pos + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [N_CH*DATA_W-1:0] exp_data;
    for (int k = 0; k < N_CH; k++) exp_data[k*DATA_W +: DATA_W] = m_mem[k];
    check({tag, ".ch_data"},    64'(bus.ch_data),    64'(exp_data));
    check({tag, ".ch_valid"},   64'(bus.ch_valid),   64'(m_cv));
    check({tag, ".sel"},        64'(bus.sel),        64'((m_pos < 0) ? 0 : m_pos));
    check({tag, ".frame_done"}, 64'(bus.frame_done), 64'(m_fd));
    check({tag, ".sync_err"},   64'(bus.sync_err),   64'(m_err));
    check({tag, ".locked"},     64'(bus.locked),     64'(m_pos >= 0));
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic beat(input string tag, input logic v, input logic s, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bus.in_valid = v; bus.in_sof = s; bus.in_data = d;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.frame_done) fd_cyc.push_back(cyc);
    model_step(v, s, d);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;
    #1;
    model_reset();
    check_all("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;
    model_reset();

    // 1: clean frame
    do_reset();
    beat("t1.b0", 1, 1, 8'h11);
    beat("t1.b1", 1, 0, 8'h22);
    beat("t1.b2", 1, 0, 8'h33);
    beat("t1.b3", 1, 0, 8'h44);
    check("t1.data_const", 64'(bus.ch_data), 64'h44332211);
    check("t1.fd_const", 64'(bus.frame_done), 64'd1);

    // 2: data before SOF is dropped
    do_reset();
    beat("t2.nosof", 1, 0, 8'hAA);
    check("t2.err_const", 64'(bus.sync_err), 64'd1);
    check("t2.data_const", 64'(bus.ch_data), 64'd0);
    beat("t2.sof", 1, 1, 8'h01);
    check("t2.sel_const", 64'(bus.sel), 64'd1);

    // 3: gaps, including SOF asserted without valid
    do_reset();
    beat("t3.b0", 1, 1, 8'h10);
    beat("t3.g0", 0, 0, 8'hFF);
    beat("t3.g1", 0, 1, 8'hEE);
    beat("t3.g2", 0, 0, 8'h00);
    beat("t3.b1", 1, 0, 8'h20);
    beat("t3.g3", 0, 1, 8'h99);
    beat("t3.b2", 1, 0, 8'h30);
    beat("t3.b3", 1, 0, 8'h40);
    check("t3.data_const", 64'(bus.ch_data), 64'h40302010);

    // 4: early SOF aborts the frame
    beat("t4.b0", 1, 1, 8'h01);
    beat("t4.b1", 1, 0, 8'h02);
    beat("t4.sof", 1, 1, 8'h05);
    check("t4.err_const", 64'(bus.sync_err), 64'd1);
    check("t4.ch1_const", 64'(bus.ch_data[DATA_W +: DATA_W]), 64'h02);
    check("t4.ch0_const", 64'(bus.ch_data[DATA_W-1:0]), 64'h05);

    // 5: missing SOF after a full frame, then relock
    beat("t5.b0", 1, 1, 8'h51);
    beat("t5.b1", 1, 0, 8'h52);
    beat("t5.b2", 1, 0, 8'h53);
    beat("t5.b3", 1, 0, 8'h54);
    beat("t5.miss", 1, 0, 8'h77);
    check("t5.lock_const", 64'(bus.locked), 64'd0);
    beat("t5.relock", 1, 1, 8'h88);

    // 6: async reset mid-frame, then back-to-back frames
    do_reset();
    beat("t6.b0", 1, 1, 8'h61);
    beat("t6.b1", 1, 0, 8'h62);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t6.async");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    beat("t6.hunt", 1, 0, 8'h63);
    fd_cyc.delete();
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < N_CH; k++)
        beat("t6.b2b", 1, (k == 0), 8'(16 * f + k));
    check("t6.fd_count", 64'(fd_cyc.size()), 64'd2);
    if (fd_cyc.size() == 2)
      check("t6.fd_spacing", 64'(fd_cyc[1] - fd_cyc[0]), 64'd4);

    // Random stream, mostly well framed with occasional violations
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic v, s;
      v = ($urandom % 4) != 0;
      s = (m_pos == 0 || m_pos < 0) ? (($urandom % 10) != 0) : (($urandom % 16) == 0);
      beat("rand", v, s, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop in case the bench stalls.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive end of a channel-interleaved link built from the team's mux cells.
- Accepts one sample per valid beat on a shared line, with in_sof marking channel 0.
- Routes each sample into a per-channel holding register and pulses that channel's valid.
- Tracks frame alignment, flags sync loss and resynchronises on the next in_sof.

Parameters:
- N_CH, 4, number of channels per frame; must be ≥2.
- DATA_W, 8, sample width in bits.
- SEL_W, $clog2(N_CH), width of the channel index (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample on in_data is present this cycle.
- in_sof  input  1  start of frame; the current sample is channel 0. Qualified by in_valid.
- in_data  input  DATA_W  interleaved sample.
- ch_data  output  N_CH*DATA_W  holding registers; channel k occupies bits [k*DATA_W +: DATA_W].
- ch_valid  output  N_CH  one-cycle pulse; bit k means ch_data slice k was updated this cycle.
- sel  output  SEL_W  channel index the next non-SOF sample will be written to.
- frame_done  output  1  one-cycle pulse when channel N_CH-1 is written.
- sync_err  output  1  one-cycle pulse on a framing violation.
- locked  output  1  high while in RUN.

Behaviour:
- Reset (async assert, takes effect immediately):
  - ch_data=0, ch_valid=0, sel=0, frame_done=0, sync_err=0, locked=0.
  - State HUNT.
  - Deassertion is used synchronously; the first capture is on the first rising edge after release.
- FSM states:
  - HUNT: not aligned; waiting for a SOF beat.
  - RUN: aligned; sel counts through the channels.
- Beat = in_valid high at a rising edge. in_sof and in_data are ignored when in_valid is low, and nothing changes except that pulses clear.
- HUNT transitions:
  - Beat with in_sof=1: write channel 0, ch_valid[0]=1, sel←1, go to RUN.
  - Beat with in_sof=0: sample is dropped, sync_err=1, stay in HUNT, sel stays 0.
- RUN, beat with in_sof=0:
  - Write channel sel and pulse ch_valid[sel].
  - If sel==N_CH-1: frame_done=1, sel←0, stay in RUN. The next beat must carry in_sof.
  - Otherwise sel←sel+1.
- RUN, beat with sel==0 and in_sof=0 (missing SOF at a frame boundary):
  - Sample is dropped, sync_err=1, go to HUNT.
- RUN, beat with in_sof=1:
  - Always written to channel 0 with ch_valid[0]=1, sel←1.
  - If sel≠0 (early SOF, short frame): also sync_err=1. frame_done is not pulsed for the aborted frame, and stale channels keep their old values.
- Latency: exactly 1 clock from beat to ch_data/ch_valid update.
- ch_data slices are written only when selected; unselected slices hold.
- At most one ch_valid bit is high in any cycle.
- sel wraps N_CH-1 → 0 and never reaches a value ≥ N_CH.
- Pulses (ch_valid, frame_done, sync_err) last exactly one cycle unless the next beat re-asserts them.
- Back-to-back frames with in_valid held high continuously are supported: zero idle cycles between the last channel and the next SOF.
- If rst asserts mid-frame, all outputs clear at once. After release the block is in HUNT, so a beat with in_sof=0 produces sync_err.
- locked is combinational from state (no extra register stage).

Test Plan (N_CH=4, DATA_W=8):
1. Reset, then beats {SOF:0x11, 0x22, 0x33, 0x44} → ch_valid walks 0001,0010,0100,1000 on consecutive cycles; frame_done pulses with the 0x44 write; ch_data=0x44332211; sel back to 0; locked=1.
2. After reset, beats 0xAA (no SOF) then SOF:0x01 → first beat gives sync_err=1, ch_data unchanged (0), locked=0; second beat writes ch0=0x01, locked=1, sel=1.
3. Gaps: SOF:0x10, idle ×3, 0x20, idle, 0x30, 0x40 → same outputs as a gapless frame, and sel holds during idle cycles. With in_valid=0 and in_sof=1 during a gap → no effect.
4. Early SOF: SOF:0x01, 0x02, SOF:0x05 → third beat gives sync_err=1, ch0=0x05, ch1 stays 0x02, no frame_done, sel=1.
5. Missing SOF: complete frame, then 0x77 without SOF → sync_err=1, state HUNT (locked=0), 0x77 dropped. A following SOF:0x88 relocks.
6. Async reset: assert rst between clock edges after the second beat → all outputs 0 before the next edge. Two back-to-back frames after release → two frame_done pulses exactly 4 cycles apart.
